// File: rtl/screen_fade_pkg.sv
// Shared game-state encodings and helpers for the fade stage.
// Also used by draw stages that select content by state.
package screen_fade_pkg;

    localparam logic [2:0] GS_START = 3'b000;
    localparam logic [2:0] GS_PLAY  = 3'b001;
    localparam logic [2:0] GS_PAUSE = 3'b010;
    localparam logic [2:0] GS_OVER  = 3'b011;

    localparam logic [4:0] LEVEL_FULL = 5'd16;
    localparam logic [4:0] LEVEL_OFF  = 5'd0;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_tim_t;

    // 4-bit channel times 0..16, keep the top nibble of the 8-bit product
    function automatic logic [3:0] scale_ch(
        input logic [3:0] c,
        input logic [4:0] level
    );
        return 4'(({4'h0, c} * {3'b000, level}) >> 4);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + RGB bundle passed between pipeline stages.
// vga_in is the consumer view, vga_out the producer view.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport vga_out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/rgb_scale.sv
// Registered per-channel brightness scaling of a 12-bit pixel.
// Forms the second pipeline stage of screen_fade.
module rgb_scale
    import screen_fade_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    input  logic [4:0]  level,
    output logic [11:0] rgb_out
);

    logic [11:0] rgb_d;
    logic [11:0] rgb_q;

    // Scale R, G and B independently by the same level
    always_comb begin
        rgb_d = {scale_ch(rgb_in[11:8], level),
                 scale_ch(rgb_in[7:4], level),
                 scale_ch(rgb_in[3:0], level)};
    end

    // Output register of the scaled pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb_out = rgb_q;

endmodule

// File: rtl/screen_fade.sv
// Fullscreen fade: ramps brightness to black on a state change,
// commits the new display state while black, then ramps back in.
module screen_fade
    import screen_fade_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] game_state,
    output logic [2:0] display_state,
    output logic       fade_busy,
    vga_if.vga_in      vga_in,
    vga_if.vga_out     vga_out
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FADE_OUT = 2'd1;
    localparam logic [1:0] S_BLACK    = 2'd2;
    localparam logic [1:0] S_FADE_IN  = 2'd3;

    typedef logic [1:0] fade_state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] FPS_LAST  = CW'(FRAMES_PER_STEP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

    fade_state_t   state_q, state_d;
    logic [4:0]    level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    target_q, target_d;
    logic [2:0]    disp_q, disp_d;
    logic          vsync_q, vsync_d;
    logic          tick;

    vga_tim_t      s1_q, s1_d;
    logic [11:0]   rgb_s1_q, rgb_s1_d;
    logic [4:0]    lvl_s1_q, lvl_s1_d;
    vga_tim_t      s2_q, s2_d;
    logic [11:0]   rgb_s2;

    assign tick = vga_in.vsync & ~vsync_q;

    // Fade sequencer: request detection per cycle, stepping per frame tick
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        disp_d   = disp_q;
        unique case (state_q)
            S_IDLE: begin
                level_d = LEVEL_FULL;
                if (game_state != disp_q) begin
                    target_d = game_state;
                    cnt_d    = '0;
                    state_d  = S_FADE_OUT;
                end
            end
            S_FADE_OUT: begin
                target_d = game_state;
                if (level_q == LEVEL_OFF) begin
                    cnt_d   = '0;
                    state_d = S_BLACK;
                end else if (tick) begin
                    if (cnt_q == FPS_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q - 5'd1;
                        if (level_q == 5'd1) begin
                            state_d = S_BLACK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_BLACK: begin
                level_d = LEVEL_OFF;
                if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        disp_d  = target_q;
                        state_d = S_FADE_IN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FADE_IN: begin
                if (game_state != target_q) begin
                    target_d = game_state;
                    cnt_d    = '0;
                    state_d  = S_FADE_OUT;
                end else if (tick) begin
                    if (cnt_q == FPS_LAST) begin
                        cnt_d   = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == LEVEL_FULL - 5'd1) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            level_q  <= LEVEL_FULL;
            cnt_q    <= '0;
            target_q <= GS_START;
            disp_q   <= GS_START;
            vsync_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            disp_q   <= disp_d;
            vsync_q  <= vsync_d;
        end
    end

    // Stage 1 captures the input stream and level, stage 2 delays timing
    always_comb begin
        vsync_d       = vga_in.vsync;
        s1_d.hcount   = vga_in.hcount;
        s1_d.vcount   = vga_in.vcount;
        s1_d.hsync    = vga_in.hsync;
        s1_d.vsync    = vga_in.vsync;
        s1_d.hblnk    = vga_in.hblnk;
        s1_d.vblnk    = vga_in.vblnk;
        rgb_s1_d      = vga_in.rgb;
        lvl_s1_d      = level_q;
        s2_d          = s1_q;
    end

    // Datapath pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            rgb_s1_q <= '0;
            lvl_s1_q <= LEVEL_FULL;
            s2_q     <= '0;
        end else begin
            s1_q     <= s1_d;
            rgb_s1_q <= rgb_s1_d;
            lvl_s1_q <= lvl_s1_d;
            s2_q     <= s2_d;
        end
    end

    rgb_scale u_rgb_scale (
        .clk     (clk),
        .rst_n   (rst_n),
        .rgb_in  (rgb_s1_q),
        .level   (lvl_s1_q),
        .rgb_out (rgb_s2)
    );

    assign vga_out.hcount = s2_q.hcount;
    assign vga_out.vcount = s2_q.vcount;
    assign vga_out.hsync  = s2_q.hsync;
    assign vga_out.vsync  = s2_q.vsync;
    assign vga_out.hblnk  = s2_q.hblnk;
    assign vga_out.vblnk  = s2_q.vblnk;
    assign vga_out.rgb    = rgb_s2;

    assign display_state = disp_q;
    assign fade_busy     = (state_q != S_IDLE);

endmodule

// File: doc/screen_fade.md
# screen_fade

Fullscreen fade stage directly downstream of the start-screen overlay in the VGA pipeline. It consumes the composited `vga_if` stream and scales every pixel's RGB by a frame-synchronous brightness level. When `game_state` changes, it fades to black, commits the new state, then fades back in. The committed state is exported as `display_state`; upstream draw stages select their content from it, so screen content only switches while the screen is black.

## Interface
Parameters:
- `FRAMES_PER_STEP`, default 2: frames each brightness level is held during a ramp.
- `HOLD_FRAMES`, default 4: frames held fully black before fade-in.

Ports:
- `clk`  in  1: pixel clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `game_state`  in  3: requested game state from game logic.
- `display_state`  out  3: committed state; upstream draw stages use this, not `game_state`.
- `fade_busy`  out  1: high in any FSM state other than IDLE.
- `vga_in`  vga_if.vga_in: timing and RGB from the previous stage.
- `vga_out`  vga_if.vga_out: the same stream with scaled RGB.

## Operation
- Brightness `level`, 5 bits, range 0..16; 16 = identity, 0 = black.
- Per 4-bit channel: out = (c × level) >> 4, using an 8-bit intermediate product.
  - Check value: c=F, level=16 gives F.
- Frame tick: rising edge of `vga_in.vsync`, detected with a one-cycle delayed copy.
  - `level` and all FSM/frame counters update only on the tick.
  - `level` is therefore constant over every visible frame.
- Register `target`, 3 bits, tracks the requested state.
- FSM (`fade_state_t`):
  - IDLE: level=16. If `game_state != display_state`, latch `target <= game_state` and go to FADE_OUT. Detection is per cycle; the ramp starts on the next tick.
  - FADE_OUT:
    - Each tick, increment the frame counter.
    - When the counter reaches FRAMES_PER_STEP-1, clear it and decrement level.
    - When level reaches 0, go to BLACK.
    - A changing `game_state` updates `target`; the fade continues.
  - BLACK:
    - level=0; count HOLD_FRAMES ticks.
    - On the final tick: `display_state <= target`, go to FADE_IN.
  - FADE_IN:
    - Increment level by the same stepping rule as FADE_OUT.
    - At level 16, go to IDLE.
    - If `game_state != target` mid-ramp: latch the new `target` and go to FADE_OUT from the current level; no jump.
- A request that returns `game_state` to `display_state` during FADE_OUT still completes the full sequence; `display_state` is rewritten with the same value.
- Minimum full cycle: 16·FPS + HOLD + 16·FPS frames, where FPS = FRAMES_PER_STEP (68 frames at defaults).

## Timing
- Datapath latency is 2 cycles for hcount, vcount, hsync, vsync, hblnk, vblnk and rgb, all kept mutually aligned.
  - Stage 1 registers the inputs and `level`.
  - Stage 2 registers the scaled RGB and the delayed timing signals.
- `display_state` changes one cycle after the final BLACK tick. That edge falls in vertical blanking, so upstream stages never switch mid-frame.
- Reset values (async, immediate):
  - All `vga_out` fields 0.
  - `display_state` = `target` = 3'b000 (start screen).
  - level=16, FSM in IDLE, counters 0, `fade_busy` = 0.
- If `game_state` ≠ 000 when reset is released, a fade sequence starts.
- Reset mid-fade returns to the reset values; there is no partial-fade memory.
- A tick in the same cycle as a state-change request is counted. The request is latched, and its ramp starts on the next tick.

## Structure
- `vga_pkg`: no additions; reuses `vga_if`.
- Shared game package: game-state encodings (GS_START=3'b000, etc.), also used by `draw_start`-style stages.
- `fade_state_t` enum: local to this module.
- One sub-module, `rgb_scale`: the registered 12-bit × 5-bit per-channel multiply-shift, forming pipeline stage 2.

## Test plan
- Reset release with `game_state`=000: `vga_out.rgb` equals `vga_in.rgb` 2 cycles later (e.g. A5C → A5C); `fade_busy`=0 for 10 frames.
- Switch `game_state` 000→001 (FPS=2, HOLD=4):
  - level steps 16→0 over 32 frames.
  - Input rgb FFF gives 777 at level 8 and 000 at level 0.
  - `display_state`=001 after the 4th black frame.
  - level returns to 16 at frame 68.
- Request 001→010 during FADE_IN at level 6: level decrements from 6 with no jump, and `display_state` goes to 010 after BLACK.
- Toggle `game_state` 000→001→000 during FADE_OUT: the full sequence runs and `display_state` ends at 000.
- Assert `rst_n` low at level 5 mid-frame: outputs go to 0 immediately; after release, level=16 and IDLE.
- Timing integrity: hsync, vsync and blanking on `vga_out` equal `vga_in` delayed by exactly 2 cycles across a full frame.
